// File: rtl/ram_seq_tester_if.sv
// RAM-side bus between the sequencer (master) and a word-addressed RAM (slave).
interface ram_seq_tester_if #(
    parameter int AW = 3,
    parameter int DW = 16
);
    logic          mem_r;
    logic          mem_w;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_d;
    logic [DW-1:0] mem_o;

    modport master (
        output mem_r,
        output mem_w,
        output mem_addr,
        output mem_d,
        input  mem_o
    );

    modport slave (
        input  mem_r,
        input  mem_w,
        input  mem_addr,
        input  mem_d,
        output mem_o
    );
endinterface

// File: rtl/ram_seq_tester.sv
// Block fill / verify sequencer for the word-addressed RAM family.
// Every output is registered; next-cycle values are computed in one always_comb.
module ram_seq_tester #(
    parameter int AW = 3,
    parameter int DW = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [AW-1:0]    base,
    input  logic [AW:0]      len,
    input  logic [DW-1:0]    seed,
    ram_seq_tester_if.master mem,
    output logic             busy,
    output logic             done,
    output logic [AW:0]      err_cnt,
    output logic [AW-1:0]    err_addr,
    output logic             err_flag
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DONE
    } state_t;

    localparam logic [AW:0]   LEN_ONE  = 1;
    localparam logic [AW-1:0] ADDR_ONE = 1;
    localparam logic [DW-1:0] DATA_ONE = 1;

    state_t        state, state_nxt;
    logic [1:0]    mode_q, mode_nxt;
    logic [AW-1:0] base_q, base_nxt;
    logic [AW:0]   len_q, len_nxt;
    logic [DW-1:0] seed_q, seed_nxt;
    logic [AW:0]   idx, idx_nxt;

    logic          r_nxt, w_nxt;
    logic [AW-1:0] addr_nxt;
    logic [DW-1:0] d_nxt;
    logic          busy_nxt, done_nxt;
    logic [AW:0]   cnt_nxt;
    logic [AW-1:0] eaddr_nxt;
    logic          eflag_nxt;

    logic          last;
    logic [DW-1:0] expect_d;
    logic          mismatch;

    // idx counts words within the current phase; len_q >= 1 whenever it is used
    assign last     = (idx == len_q - LEN_ONE);
    assign expect_d = seed_q + DW'(idx);
    assign mismatch = (mem.mem_o != expect_d);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            mode_q       <= '0;
            base_q       <= '0;
            len_q        <= '0;
            seed_q       <= '0;
            idx          <= '0;
            mem.mem_r    <= 1'b0;
            mem.mem_w    <= 1'b0;
            mem.mem_addr <= '0;
            mem.mem_d    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err_cnt      <= '0;
            err_addr     <= '0;
            err_flag     <= 1'b0;
        end else begin
            state        <= state_nxt;
            mode_q       <= mode_nxt;
            base_q       <= base_nxt;
            len_q        <= len_nxt;
            seed_q       <= seed_nxt;
            idx          <= idx_nxt;
            mem.mem_r    <= r_nxt;
            mem.mem_w    <= w_nxt;
            mem.mem_addr <= addr_nxt;
            mem.mem_d    <= d_nxt;
            busy         <= busy_nxt;
            done         <= done_nxt;
            err_cnt      <= cnt_nxt;
            err_addr     <= eaddr_nxt;
            err_flag     <= eflag_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mode_nxt  = mode_q;
        base_nxt  = base_q;
        len_nxt   = len_q;
        seed_nxt  = seed_q;
        idx_nxt   = idx;
        r_nxt     = 1'b0;
        w_nxt     = 1'b0;
        addr_nxt  = mem.mem_addr;
        d_nxt     = mem.mem_d;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        cnt_nxt   = err_cnt;
        eaddr_nxt = err_addr;
        eflag_nxt = err_flag;

        unique case (state)
            S_IDLE: begin
                if (start) begin
                    mode_nxt  = mode;
                    base_nxt  = base;
                    len_nxt   = len;
                    seed_nxt  = seed;
                    idx_nxt   = '0;
                    cnt_nxt   = '0;
                    eaddr_nxt = '0;
                    eflag_nxt = 1'b0;
                    if (len == '0) begin
                        state_nxt = S_DONE;
                        done_nxt  = 1'b1;
                    end else if (mode == 2'b01) begin
                        state_nxt = S_READ;
                        busy_nxt  = 1'b1;
                        r_nxt     = 1'b1;
                        addr_nxt  = base;
                        d_nxt     = '0;
                    end else begin
                        state_nxt = S_WRITE;
                        busy_nxt  = 1'b1;
                        w_nxt     = 1'b1;
                        addr_nxt  = base;
                        d_nxt     = seed;
                    end
                end
            end

            S_WRITE: begin
                if (!last) begin
                    idx_nxt  = idx + LEN_ONE;
                    busy_nxt = 1'b1;
                    w_nxt    = 1'b1;
                    addr_nxt = mem.mem_addr + ADDR_ONE;
                    d_nxt    = mem.mem_d + DATA_ONE;
                end else if (mode_q == 2'b10) begin
                    // fill-then-verify rolls straight into the read phase
                    state_nxt = S_READ;
                    idx_nxt   = '0;
                    busy_nxt  = 1'b1;
                    r_nxt     = 1'b1;
                    addr_nxt  = base_q;
                    d_nxt     = '0;
                end else begin
                    state_nxt = S_DONE;
                    done_nxt  = 1'b1;
                end
            end

            S_READ: begin
                if (mismatch) begin
                    if (err_cnt != '1) begin
                        cnt_nxt = err_cnt + LEN_ONE;
                    end
                    if (!err_flag) begin
                        eaddr_nxt = mem.mem_addr;
                        eflag_nxt = 1'b1;
                    end
                end
                if (!last) begin
                    idx_nxt  = idx + LEN_ONE;
                    busy_nxt = 1'b1;
                    r_nxt    = 1'b1;
                    addr_nxt = mem.mem_addr + ADDR_ONE;
                    d_nxt    = '0;
                end else begin
                    state_nxt = S_DONE;
                    done_nxt  = 1'b1;
                end
            end

            S_DONE: begin
                state_nxt = S_IDLE;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_ram_seq_tester.sv
// Bench for ram_seq_tester: directed vector table, hand sequences and random
// commands checked against an array-based model of the RAM and command results.
module tb_ram_seq_tester;
    localparam int AW    = 3;
    localparam int DW    = 16;
    localparam int WORDS = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [1:0]    mode;
    logic [AW-1:0] base;
    logic [AW:0]   len;
    logic [DW-1:0] seed;
    logic          busy;
    logic          done;
    logic [AW:0]   err_cnt;
    logic [AW-1:0] err_addr;
    logic          err_flag;

    ram_seq_tester_if #(.AW(AW), .DW(DW)) mem ();

    ram_seq_tester #(.AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mode     (mode),
        .base     (base),
        .len      (len),
        .seed     (seed),
        .mem      (mem),
        .busy     (busy),
        .done     (done),
        .err_cnt  (err_cnt),
        .err_addr (err_addr),
        .err_flag (err_flag)
    );

    always #5 clk = ~clk;

    // RAM8 with a backdoor port used only while the sequencer is idle
    logic [DW-1:0] ram [WORDS];
    logic          bd_we;
    logic [AW-1:0] bd_addr;
    logic [DW-1:0] bd_data;

    always @(posedge clk) begin
        if (bd_we) ram[bd_addr] <= bd_data;
        else if (mem.mem_w) ram[mem.mem_addr] <= mem.mem_d;
    end
    assign mem.mem_o = mem.mem_r ? ram[mem.mem_addr] : '0;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    // Reference model: expected contents of RAM and the per-cycle access trace
    typedef struct {
        logic          w;
        logic          r;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } acc_t;

    logic [DW-1:0] shadow [WORDS];
    acc_t          exp_q[$];
    int            m_cnt;
    logic [AW-1:0] m_eaddr;
    logic          m_flag;
    logic [AW-1:0] last_a;
    logic [DW-1:0] last_d;

    task automatic model_cmd(input logic [1:0] md, input int b, input int n, input int s);
        acc_t e;
        exp_q.delete();
        m_cnt   = 0;
        m_eaddr = '0;
        m_flag  = 1'b0;
        if (md != 2'b01) begin
            for (int i = 0; i < n; i++) begin
                e.w = 1'b1; e.r = 1'b0;
                e.a = AW'((b + i) % WORDS);
                e.d = DW'((s + i) % 65536);
                shadow[e.a] = e.d;
                exp_q.push_back(e);
            end
        end
        if (md == 2'b01 || md == 2'b10) begin
            for (int i = 0; i < n; i++) begin
                e.w = 1'b0; e.r = 1'b1;
                e.a = AW'((b + i) % WORDS);
                e.d = '0;
                if (shadow[e.a] !== DW'((s + i) % 65536)) begin
                    if (m_cnt < (1 << (AW + 1)) - 1) m_cnt++;
                    if (!m_flag) begin
                        m_flag  = 1'b1;
                        m_eaddr = e.a;
                    end
                end
                exp_q.push_back(e);
            end
        end
        if (exp_q.size() > 0) begin
            last_a = exp_q[exp_q.size() - 1].a;
            last_d = exp_q[exp_q.size() - 1].d;
        end
    endtask

    task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        @(negedge clk);
        bd_we = 1'b0;
        shadow[a] = d;
    endtask

    task automatic zero_ram();
        for (int a = 0; a < WORDS; a++) poke(AW'(a), '0);
    endtask

    task automatic check_ram(input string name);
        for (int a = 0; a < WORDS; a++) check(name, ram[a], shadow[a]);
    endtask

    task automatic run_cmd(input logic [1:0] md, input logic [AW-1:0] b, input logic [AW:0] n,
                           input logic [DW-1:0] s, output int lat);
        int n_acc;
        int budget;
        model_cmd(md, int'(b), int'(n), int'(s));
        n_acc = exp_q.size();
        @(negedge clk);
        start = 1'b1; mode = md; base = b; len = n; seed = s;
        @(posedge clk);
        #1;
        start = 1'b0;
        mode  = 2'($urandom);
        base  = 3'($urandom);
        len   = 4'($urandom);
        seed  = 16'($urandom);
        lat    = -1;
        budget = 2 * WORDS + 4;
        for (int c = 1; c <= budget && lat < 0; c++) begin
            @(negedge clk);
            if (c <= n_acc) begin
                check("access", {busy, done, mem.mem_w, mem.mem_r, mem.mem_addr, mem.mem_d},
                      {1'b1, 1'b0, exp_q[c-1].w, exp_q[c-1].r, exp_q[c-1].a, exp_q[c-1].d});
            end
            if (done) begin
                lat = c;
                check("done_cycle", {busy, mem.mem_r, mem.mem_w, mem.mem_addr, mem.mem_d},
                      {1'b0, 1'b0, 1'b0, last_a, last_d});
                check("latency", c, n_acc + 1);
                check("err_cnt", err_cnt, m_cnt);
                check("err_addr", err_addr, m_eaddr);
                check("err_flag", err_flag, m_flag);
            end
        end
        if (lat < 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no done within %0d cycles", budget);
        end
        @(negedge clk);
        check("done_pulse", {done, busy}, 2'b00);
        check_ram("ram_word");
    endtask

    typedef struct {
        logic [1:0]    md;
        logic [AW-1:0] b;
        logic [AW:0]   n;
        logic [DW-1:0] s;
        bit            clr;
        bit            pk;
        logic [AW-1:0] pk_a;
        logic [DW-1:0] pk_d;
        int            e_cnt;
        logic [AW-1:0] e_addr;
        bit            e_flag;
        int            e_lat;
    } vec_t;

    vec_t vecs [9];
    int   lat;
    int   wcount, rcount, dcount;

    initial begin
        vecs[0] = '{2'b10, 3'd0, 4'd8, 16'h1000, 1'b0, 1'b0, 3'd0, 16'h0000, 0, 3'd0, 1'b0, 17};
        vecs[1] = '{2'b01, 3'd0, 4'd8, 16'h1000, 1'b0, 1'b1, 3'd5, 16'hDEAD, 1, 3'd5, 1'b1, 9};
        vecs[2] = '{2'b00, 3'd6, 4'd4, 16'hFFFE, 1'b0, 1'b0, 3'd0, 16'h0000, 0, 3'd0, 1'b0, 5};
        vecs[3] = '{2'b01, 3'd6, 4'd4, 16'hFFFE, 1'b0, 1'b0, 3'd0, 16'h0000, 0, 3'd0, 1'b0, 5};
        vecs[4] = '{2'b01, 3'd3, 4'd8, 16'h0001, 1'b1, 1'b0, 3'd0, 16'h0000, 8, 3'd3, 1'b1, 9};
        vecs[5] = '{2'b01, 3'd0, 4'd0, 16'h0000, 1'b0, 1'b0, 3'd0, 16'h0000, 0, 3'd0, 1'b0, 1};
        vecs[6] = '{2'b11, 3'd2, 4'd3, 16'h00AB, 1'b0, 1'b0, 3'd0, 16'h0000, 0, 3'd0, 1'b0, 4};
        vecs[7] = '{2'b01, 3'd2, 4'd3, 16'h00AB, 1'b0, 1'b0, 3'd0, 16'h0000, 0, 3'd0, 1'b0, 4};
        vecs[8] = '{2'b10, 3'd7, 4'd1, 16'h0001, 1'b0, 1'b0, 3'd0, 16'h0000, 0, 3'd0, 1'b0, 3};

        rst = 1'b1; start = 1'b0; mode = '0; base = '0; len = '0; seed = '0;
        bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        last_a = '0; last_d = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", {mem.mem_r, mem.mem_w, mem.mem_addr, mem.mem_d, busy, done,
                              err_cnt, err_addr, err_flag}, '0);
        zero_ram();
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            if (vecs[i].clr) zero_ram();
            if (vecs[i].pk) poke(vecs[i].pk_a, vecs[i].pk_d);
            run_cmd(vecs[i].md, vecs[i].b, vecs[i].n, vecs[i].s, lat);
            check("vec_latency", lat, vecs[i].e_lat);
            check("vec_err", {err_cnt, err_addr, err_flag},
                  {4'(vecs[i].e_cnt), vecs[i].e_addr, vecs[i].e_flag});
        end

        // starts during busy and during the done cycle must be ignored
        model_cmd(2'b00, 0, 3, 16'h5000);
        @(negedge clk);
        start = 1'b1; mode = 2'b00; base = 3'd0; len = 4'd3; seed = 16'h5000;
        @(posedge clk);
        #1;
        start = 1'b0;
        wcount = 0; rcount = 0; dcount = 0;
        for (int c = 1; c <= 10; c++) begin
            if (c == 2 || c == 4) begin
                start = 1'b1; mode = 2'b01; base = 3'd3; len = 4'd8; seed = 16'h1234;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (mem.mem_w) wcount++;
            if (mem.mem_r) rcount++;
            if (done) begin
                dcount++;
                check("ign_done_cycle", c, 4);
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        check("ign_writes", wcount, 3);
        check("ign_reads", rcount, 0);
        check("ign_dones", dcount, 1);
        check_ram("ign_ram");

        // leave errors latched, then reset in the middle of a fill
        zero_ram();
        run_cmd(2'b01, 3'd0, 4'd8, 16'h0001, lat);
        check("pre_rst_err", {err_cnt, err_addr, err_flag}, {4'd8, 3'd0, 1'b1});
        @(negedge clk);
        start = 1'b1; mode = 2'b00; base = 3'd4; len = 4'd8; seed = 16'h7000;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_third_write", {mem.mem_w, mem.mem_addr, mem.mem_d}, {1'b1, 3'd6, 16'h7002});
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_outputs", {mem.mem_r, mem.mem_w, busy, done, mem.mem_addr, mem.mem_d,
                              err_cnt, err_addr, err_flag}, '0);
        shadow[4] = 16'h7000; shadow[5] = 16'h7001; shadow[6] = 16'h7002;
        last_a = '0; last_d = '0;
        check_ram("rst_ram");

        for (int k = 0; k < 40; k++) begin
            logic [1:0]    rmd;
            logic [AW-1:0] rb;
            logic [AW:0]   rn;
            logic [DW-1:0] rs;
            rmd = 2'($urandom_range(0, 3));
            rb  = 3'($urandom);
            rn  = 4'($urandom_range(0, WORDS));
            rs  = 16'($urandom);
            if ($urandom_range(0, 3) == 0) poke(3'($urandom), 16'($urandom));
            run_cmd(rmd, rb, rn, rs, lat);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
